// File: rtl/sar_ctrl_sync.sv
// sar_ctrl_sync: synchronous SAR conversion controller, MSB-first CDAC drive.
// Define SAR_CMP_TIMEOUT_EN to enable the comparator-ready timeout.
module sar_ctrl_sync #(
  parameter int NBIT       = 9,
  parameter int SAMPLE_CYC = 2,
  parameter int TMO_CYC    = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            CMP_RDY,
  input  logic            CMP_P,
  input  logic            CMP_N,
  output logic            CKS,
  output logic            CKSB,
  output logic            CMP_EN,
  output logic [NBIT-1:0] SWP,
  output logic [NBIT-1:0] SWN,
  output logic [NBIT-1:0] DOUT,
  output logic            VALID,
  output logic            BUSY,
  output logic            TMO_FLAG
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_COMPARE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int KW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam logic [KW-1:0] K_MSB  = KW'(NBIT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_CYC - 1);

  state_t          state_q;
  state_t          state_d;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   k_d;
  logic [SW-1:0]   scnt_q;
  logic [SW-1:0]   scnt_d;
  logic [NBIT-1:0] swp_d;
  logic [NBIT-1:0] swn_d;
  logic [NBIT-1:0] dout_d;
  logic [NBIT-1:0] sel;
  logic            start_acc;
  logic            tmo_hit;
  logic            take;
  logic            bit_p;
  logic            bit_n;

  assign start_acc = (state_q == S_IDLE) && START;
  assign sel       = {{(NBIT-1){1'b0}}, 1'b1} << k_q;
  assign take      = CMP_RDY || tmo_hit;
  assign bit_p     = tmo_hit ? 1'b1 : CMP_P;
  assign bit_n     = tmo_hit ? 1'b0 : CMP_N;

`ifdef SAR_CMP_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] tcnt_q;
  logic          tmo_q;

  // Counter restarts on every WAIT entry since COMPARE always precedes WAIT
  assign tmo_hit = (state_q == S_WAIT) && !CMP_RDY &&
                   (tcnt_q == T_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (state_q != S_WAIT)
        tcnt_q <= '0;
      else if (!CMP_RDY)
        tcnt_q <= tcnt_q + 1'b1;
      if (start_acc)
        tmo_q <= 1'b0;
      else if (tmo_hit)
        tmo_q <= 1'b1;
    end
  end

  assign TMO_FLAG = tmo_q;
`else
  assign tmo_hit  = 1'b0;
  assign TMO_FLAG = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    scnt_d  = scnt_q;
    swp_d   = SWP;
    swn_d   = SWN;
    dout_d  = DOUT;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_SAMPLE;
          scnt_d  = '0;
          swp_d   = '0;
          swn_d   = '0;
        end
      end
      S_SAMPLE: begin
        if (scnt_q == S_LAST) begin
          state_d = S_COMPARE;
          k_d     = K_MSB;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_COMPARE: state_d = S_WAIT;
      S_WAIT: begin
        if (take) begin
          swp_d = (SWP & ~sel) | (bit_p ? sel : '0);
          swn_d = (SWN & ~sel) | (bit_n ? sel : '0);
          if (k_q == '0) begin
            state_d = S_DONE;
            dout_d  = swp_d;
          end else begin
            k_d     = k_q - 1'b1;
            state_d = S_COMPARE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge CLK) begin
    if (RST) begin
      k_q    <= '0;
      scnt_q <= '0;
      SWP    <= '0;
      SWN    <= '0;
      DOUT   <= '0;
      CKS    <= 1'b0;
      CKSB   <= 1'b1;
      CMP_EN <= 1'b0;
      VALID  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      k_q    <= k_d;
      scnt_q <= scnt_d;
      SWP    <= swp_d;
      SWN    <= swn_d;
      DOUT   <= dout_d;
      CKS    <= (state_d == S_SAMPLE);
      CKSB   <= (state_d != S_SAMPLE);
      CMP_EN <= (state_d == S_COMPARE);
      VALID  <= (state_d == S_DONE);
      BUSY   <= (state_d inside {S_SAMPLE, S_COMPARE, S_WAIT});
    end
  end

endmodule

// File: tb/tb_sar_ctrl_sync.sv
// tb_sar_ctrl_sync: scoreboard bench for sar_ctrl_sync.
// Covers default and NBIT=4/SAMPLE_CYC=1 instances.
`timescale 1ns/1ps
module tb_sar_ctrl_sync;

  localparam logic [32:0] RST9 = {6'b010000, 27'd0};

  logic clk = 1'b0;
  logic rst;
  logic start, cmp_rdy, cmp_p, cmp_n;
  logic cks, cksb, cmp_en, valid, busy, tmo_flag;
  logic [8:0] swp, swn, dout;

  logic start4, cmp_rdy4, cmp_p4, cmp_n4;
  logic cks4, cksb4, cmp_en4, valid4, busy4, tmo_flag4;
  logic [3:0] swp4, swn4, dout4;

  always #5 clk = ~clk;

  sar_ctrl_sync u9 (
    .CLK(clk), .RST(rst), .START(start),
    .CMP_RDY(cmp_rdy), .CMP_P(cmp_p), .CMP_N(cmp_n),
    .CKS(cks), .CKSB(cksb), .CMP_EN(cmp_en),
    .SWP(swp), .SWN(swn), .DOUT(dout),
    .VALID(valid), .BUSY(busy), .TMO_FLAG(tmo_flag)
  );

  sar_ctrl_sync #(.NBIT(4), .SAMPLE_CYC(1), .TMO_CYC(8)) u4 (
    .CLK(clk), .RST(rst), .START(start4),
    .CMP_RDY(cmp_rdy4), .CMP_P(cmp_p4), .CMP_N(cmp_n4),
    .CKS(cks4), .CKSB(cksb4), .CMP_EN(cmp_en4),
    .SWP(swp4), .SWN(swn4), .DOUT(dout4),
    .VALID(valid4), .BUSY(busy4), .TMO_FLAG(tmo_flag4)
  );

  typedef struct {
    logic [8:0] dout;
    logic [8:0] swn;
    int         lat;
    int         st;
  } exp_t;

  exp_t q9[$];
  exp_t q4[$];
  exp_t e9, e4;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int vcnt9 = 0;
  int vcnt4 = 0;
  int en_cnt = 0;

  logic [8:0] pat;
  int extra;
  bit tie;
  int hang;
  int bidx9;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop expected result whenever a VALID strobe appears
  always @(negedge clk) begin
    if (cmp_en) en_cnt++;
    if (valid) begin
      vcnt9++;
      if (q9.size() == 0) begin
        total++;
        bad++;
        $display("FAIL valid9: got unexpected VALID want none");
      end else begin
        e9 = q9.pop_front();
        chk("dout9", dout, e9.dout);
        chk("swn9", swn, e9.swn);
        chk("lat9", cyc - e9.st, e9.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (valid4) begin
      vcnt4++;
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL valid4: got unexpected VALID want none");
      end else begin
        e4 = q4.pop_front();
        chk("dout4", dout4, e4.dout);
        chk("swn4", swn4, e4.swn);
        chk("lat4", cyc - e4.st, e4.lat);
      end
    end
  end

  // Comparator model for the default instance
  initial begin
    bidx9 = 8;
    cmp_rdy = 1'b0;
    cmp_p = 1'b0;
    cmp_n = 1'b0;
    forever begin
      @(negedge clk);
      cmp_rdy = tie;
      if (cks) bidx9 = 8;
      if (cmp_en && bidx9 >= 0) begin
        cmp_p = pat[bidx9];
        cmp_n = ~pat[bidx9];
        if (bidx9 == hang) begin
          cmp_p = 1'b0;
          cmp_n = 1'b1;
        end else begin
          repeat (extra + 1) @(negedge clk);
          cmp_rdy = 1'b1;
        end
        bidx9--;
      end
    end
  end

  task automatic go(input logic [8:0] d, input logic [8:0] sn,
                    input int lat);
    exp_t e;
    e.dout = d;
    e.swn = sn;
    e.lat = lat;
    e.st = cyc;
    q9.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input bit poke);
    int n;
    n = 0;
    while (!valid && n < 400) begin
      tick();
      n++;
    end
    chk(nm, valid, 1);
    if (valid && poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end else begin
      tick();
    end
  endtask

  task automatic go4();
    exp_t e;
    e.dout = 9'h00F;
    e.swn = 9'h000;
    e.lat = 10;
    e.st = cyc;
    q4.push_back(e);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic wait_v4(input string nm);
    int n;
    n = 0;
    while (!valid4 && n < 100) begin
      tick();
      n++;
    end
    chk(nm, valid4, 1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    int n;
    rst = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    cmp_rdy4 = 1'b1;
    cmp_p4 = 1'b1;
    cmp_n4 = 1'b0;
    pat = '0;
    extra = 0;
    tie = 1'b0;
    hang = -1;
    repeat (3) tick();
    chk("reset9", {cks, cksb, cmp_en, valid, busy, tmo_flag,
                   swp, swn, dout}, RST9);
    chk("reset4", {cks4, cksb4, cmp_en4, valid4, busy4, tmo_flag4,
                   swp4, swn4, dout4}, {6'b010000, 12'd0});
    rst = 1'b0;
    tick();

    // Alternating pattern, ready tied high
    pat = 9'h155;
    tie = 1'b1;
    en_cnt = 0;
    go(9'h155, 9'h0AA, 21);
    wait_valid("t1_valid", 1'b0);
    chk("cmp_en_pulses", en_cnt, 9);

    // Ready delayed 3 cycles on every bit
    tie = 1'b0;
    extra = 3;
    pat = 9'h193;
    go(9'h193, 9'h06C, 48);
    wait_valid("t2_valid", 1'b0);

    // Reset during the bit-4 WAIT
    extra = 2;
    pat = 9'h0F0;
    en_cnt = 0;
    v0 = vcnt9;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (en_cnt < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_bit4", en_cnt, 5);
    chk("bit4_wait_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset", {cks, cksb, cmp_en, valid, busy, tmo_flag,
                      swp, swn, dout}, RST9);
    repeat (6) tick();
    chk("no_valid_reset", vcnt9 - v0, 0);
    extra = 0;
    go(9'h0F0, 9'h10F, 21);
    wait_valid("t3_valid", 1'b0);

    // START during BUSY and in the DONE cycle
    extra = 1;
    pat = 9'h1A5;
    v0 = vcnt9;
    go(9'h1A5, 9'h05A, 30);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("t4_valid", 1'b1);
    repeat (4) begin
      chk("busy_after_done", busy, 0);
      tick();
    end
    chk("one_valid", vcnt9 - v0, 1);
    extra = 0;

`ifdef SAR_CMP_TIMEOUT_EN
    pat = 9'h000;
    hang = 3;
    go(9'h008, 9'h1F7, 28);
    wait_valid("t5_valid", 1'b0);
    chk("tmo_set", tmo_flag, 1);
    chk("swp_tmo", swp, 9'h008);
    hang = -1;
    pat = 9'h155;
    go(9'h155, 9'h0AA, 21);
    chk("tmo_clear", tmo_flag, 0);
    wait_valid("t6_valid", 1'b0);
`else
    pat = 9'h000;
    hang = 3;
    v0 = vcnt9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    chk("wait_blocks", busy, 1);
    chk("tmo_tied", tmo_flag, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hang = -1;
    repeat (4) tick();
    chk("no_valid_hang", vcnt9 - v0, 0);
`endif

    // NBIT=4, SAMPLE_CYC=1 instance
    go4();
    wait_v4("t7_valid");
    chk("swp4_before", swp4, 4'hF);
    go4();
    chk("swp4_clr", swp4, 4'h0);
    chk("cks4_sample", cks4, 1);
    wait_v4("t8_valid");

    chk("q9_empty", q9.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
